idle_shutdown: RTL and testbench

Inactivity watchdog that produces the power-off request consumed by the power/mode starter. It watches the starter's `model` output and the driver controls. When the car is powered and left idle for `IDLE_SEC` seconds, it issues a one-cycle `power_off_req` pulse. It then waits for the starter to acknowledge by driving `model` to 2'b00, and re-issues the pulse if no acknowledge arrives.

---
 rtl/idle_shutdown.sv | 124 ++++++++++++
 tb/tb_idle_shutdown.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/idle_shutdown.sv
// Inactivity watchdog: counts idle seconds while powered and pulses a power-off
// request, re-issuing it until the starter acknowledges by returning to mode 00.
module idle_shutdown #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned IDLE_SEC    = 10,
    parameter int unsigned WARN_SEC    = 3,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] model,
    input  logic       throttle,
    input  logic       brake,
    input  logic       clutch,
    input  logic       reverse,
    input  logic       turn_left,
    input  logic       turn_right,
    output logic       power_off_req,
    output logic       idle_warn,
    output logic [3:0] idle_left
);

    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        COUNT    = 2'd1,
        REQ      = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [PRESC_W-1:0]   presc, presc_n;
    logic [ACK_W-1:0]     ack_cnt, ack_cnt_n;
    logic [3:0]           idle_left_n;
    logic                 req_n;
    logic                 warn_n;
    logic                 activity;
    logic                 powered;

    // Auto mode counts as permanent activity, so it never times out.
    assign activity = throttle | brake | clutch | reverse | turn_left | turn_right
                    | (model == 2'b11);
    assign powered  = (model != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= OFF;
            presc         <= '0;
            ack_cnt       <= '0;
            idle_left     <= 4'd0;
            power_off_req <= 1'b0;
            idle_warn     <= 1'b0;
        end else begin
            state         <= state_n;
            presc         <= presc_n;
            ack_cnt       <= ack_cnt_n;
            idle_left     <= idle_left_n;
            power_off_req <= req_n;
            idle_warn     <= warn_n;
        end
    end

    always_comb begin
        state_n     = state;
        presc_n     = presc;
        ack_cnt_n   = ack_cnt;
        idle_left_n = idle_left;
        req_n       = 1'b0;

        case (state)
            OFF: begin
                idle_left_n = 4'd0;
                presc_n     = '0;
                ack_cnt_n   = '0;
                if (powered) begin
                    state_n     = COUNT;
                    idle_left_n = 4'(IDLE_SEC);
                end
            end
            COUNT: begin
                if (!powered) begin
                    state_n     = OFF;
                    idle_left_n = 4'd0;
                    presc_n     = '0;
                end else if (activity) begin
                    idle_left_n = 4'(IDLE_SEC);
                    presc_n     = '0;
                end else if (presc == PRESC_W'(CLK_HZ - 1)) begin
                    presc_n     = '0;
                    idle_left_n = idle_left - 4'd1;
                    if (idle_left == 4'd1) begin
                        state_n = REQ;
                        req_n   = 1'b1;
                    end
                end else begin
                    presc_n = presc + PRESC_W'(1);
                end
            end
            REQ: begin
                ack_cnt_n = '0;
                state_n   = powered ? WAIT_ACK : OFF;
            end
            WAIT_ACK: begin
                // Shutdown is committed here; driver activity is deliberately ignored.
                if (!powered) begin
                    state_n   = OFF;
                    ack_cnt_n = '0;
                end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                end else begin
                    ack_cnt_n = ack_cnt + ACK_W'(1);
                end
            end
            default: state_n = OFF;
        endcase

        warn_n = (state_n == REQ) || (state_n == WAIT_ACK)
              || ((state_n == COUNT) && (idle_left_n <= 4'(WARN_SEC)));
    end

endmodule

// File: tb/tb_idle_shutdown.sv
// Directed bench for idle_shutdown with a 10-cycle "second" and a 3-second timeout.
module tb_idle_shutdown;

    logic       clk;
    logic       rst_n;
    logic [1:0] model;
    logic       throttle, brake, clutch, reverse, turn_left, turn_right;
    logic       power_off_req;
    logic       idle_warn;
    logic [3:0] idle_left;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    idle_shutdown #(
        .CLK_HZ     (10),
        .IDLE_SEC   (3),
        .WARN_SEC   (1),
        .ACK_TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .model        (model),
        .throttle     (throttle),
        .brake        (brake),
        .clutch       (clutch),
        .reverse      (reverse),
        .turn_left    (turn_left),
        .turn_right   (turn_right),
        .power_off_req(power_off_req),
        .idle_warn    (idle_warn),
        .idle_left    (idle_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one edge and settle; outputs read here are "after the edge".
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input int req, input int warn, input int left);
        check({tag, "_req"},  int'(power_off_req), req);
        check({tag, "_warn"}, int'(idle_warn),     warn);
        check({tag, "_left"}, int'(idle_left),     left);
    endtask

    int bad;

    initial begin
        rst_n = 1'b0; model = 2'b01;
        throttle = 1'b0; brake = 1'b0; clutch = 1'b0;
        reverse = 1'b0; turn_left = 1'b0; turn_right = 1'b0;

        // Reset holds everything at zero even with model powered.
        #2;
        check_outs("rst", 0, 0, 0);
        step(3);
        check_outs("rst_hold", 0, 0, 0);
        rst_n = 1'b1;                       // released after edge 0

        // Idle countdown; edge 1 is edge k
        step();
        check_outs("k", 0, 0, 3);
        step(9);
        check("k9_left", int'(idle_left), 3);
        step();
        check_outs("k10", 0, 0, 2);
        step(10);
        check_outs("k20", 0, 1, 1);
        step(9);
        check("k29_req", int'(power_off_req), 0);
        step();
        check_outs("k30", 1, 1, 0);
        step();
        check_outs("k31", 0, 1, 0);
        step();
        model = 2'b00;
        step();
        check_outs("k33_ack", 0, 0, 0);

        // Activity rescue at idle_left == 1
        model = 2'b01;
        step();
        check("resc_load", int'(idle_left), 3);
        step(20);
        check_outs("resc_pre", 0, 1, 1);
        throttle = 1'b1;
        step();
        throttle = 1'b0;
        check_outs("resc_hit", 0, 0, 3);
        bad = 0;
        for (int i = 0; i < 29; i++) begin
            step();
            if (power_off_req) bad++;
        end
        check("resc_noreq", bad, 0);
        step();
        check("resc_req", int'(power_off_req), 1);

        // No acknowledge: pulses every 5 cycles; brake in WAIT_ACK is ignored
        brake = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("noack_%0d", i), int'(power_off_req), (i % 5 == 0) ? 1 : 0);
        end
        check("noack_warn", int'(idle_warn), 1);
        brake = 1'b0;

        // Auto mode holds the count
        model = 2'b00;
        step();
        check_outs("auto_off", 0, 0, 0);
        model = 2'b11;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (idle_left != 4'd3 || power_off_req) bad++;
        end
        check("auto_hold", bad, 0);
        model = 2'b01;
        bad = 0;
        for (int i = 0; i < 29; i++) begin
            step();
            if (power_off_req) bad++;
        end
        check("auto_noreq", bad, 0);
        step();
        check("auto_req30", int'(power_off_req), 1);

        // Async reset mid-WAIT_ACK, between edges
        step(2);
        check("wa_warn", int'(idle_warn), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0);
        #2;
        rst_n = 1'b1;
        step();
        check_outs("restart", 0, 0, 3);
        step(10);
        check("restart_k10", int'(idle_left), 2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
